// File: rtl/ifu.sv
// Instruction fetch unit: fetches words from imem over req/ack and hands {inst, pc} to the decoder.
// Latency: ack in cycle N -> valid_o_ifu in N+1; handshake in M -> next request in M+1.
// Backpressure: holds one instruction while ready_i_ifu is low; no new request until it is consumed.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o_ifu,
    output logic [31:0] pc_o_ifu,
    output logic        valid_o_ifu,
    input  logic        ready_i_ifu,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] pending_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    logic [31:0] redirect_pc_w;
    logic [31:0] pending_d;

    // Redirect targets are word aligned; in DISCARD the newest redirect replaces the pending target.
    always_comb begin
        redirect_pc_w = {redirect_pc_i[31:2], 2'b00};
        pending_d     = pending_q;
        if (state_q == DISCARD && redirect_i) begin
            pending_d = redirect_pc_w;
        end
    end

    // Fetch state machine: owns the fetch PC, the pending redirect target and the output buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pending_q  <= 32'h0;
            inst_q     <= 32'h0;
            pc_q       <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_pc_w;
                    end
                    state_q <= REQ;
                end
                REQ: begin
                    if (imem_ack_i) begin
                        if (redirect_i) begin
                            // Returned word belongs to the old path: drop it and refetch.
                            fetch_pc_q <= redirect_pc_w;
                            state_q    <= REQ;
                        end else begin
                            inst_q  <= imem_rdata_i;
                            pc_q    <= fetch_pc_q;
                            state_q <= HOLD;
                        end
                    end else if (redirect_i) begin
                        // Request cannot be withdrawn; wait out its ack before switching path.
                        pending_q <= redirect_pc_w;
                        state_q   <= DISCARD;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redirect_pc_w;
                        state_q    <= REQ;
                    end else if (ready_i_ifu) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= REQ;
                    end
                end
                DISCARD: begin
                    pending_q <= pending_d;
                    if (imem_ack_i) begin
                        fetch_pc_q <= pending_d;
                        state_q    <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are pure decode of the state register or straight register copies.
    assign imem_req_o  = (state_q == REQ) || (state_q == DISCARD);
    assign imem_addr_o = fetch_pc_q;
    assign valid_o_ifu = (state_q == HOLD);
    assign inst_o_ifu  = inst_q;
    assign pc_o_ifu    = pc_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: table of per-cycle inputs and expected outputs, plus async-reset sequence.
// Inputs are applied 1 time unit after the rising edge; outputs are checked before the next edge.
// Memory acks and decoder ready are scripted per cycle in the table.
module tb_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o_ifu;
    logic [31:0] pc_o_ifu;
    logic        valid_o_ifu;
    logic        ready_i_ifu;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o_ifu   (inst_o_ifu),
        .pc_o_ifu     (pc_o_ifu),
        .valid_o_ifu  (valid_o_ifu),
        .ready_i_ifu  (ready_i_ifu),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h1111_0001, A2 = 32'h1111_0002;
    localparam logic [31:0] A3 = 32'h1111_0003, A4 = 32'h1111_0004, A5 = 32'h1111_0005;
    localparam logic [31:0] A6 = 32'h1111_0006, A7 = 32'h1111_0007, A8 = 32'h1111_0008;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    task automatic add(input logic redir, input logic [31:0] rpc, input logic ack,
                       input logic [31:0] rdata, input logic rdy, input logic e_req,
                       input logic [31:0] e_addr, input logic e_vld,
                       input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_inst = e_inst; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_inst, input logic [31:0] e_pc);
        chk("req",  idx, {31'b0, imem_req_o},  {31'b0, e_req});
        chk("addr", idx, imem_addr_o,          e_addr);
        chk("vld",  idx, {31'b0, valid_o_ifu}, {31'b0, e_vld});
        chk("inst", idx, inst_o_ifu,           e_inst);
        chk("pc",   idx, pc_o_ifu,             e_pc);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; imem_ack_i = 1'b0; imem_rdata_i = 32'h0;
        ready_i_ifu = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        //   redir rpc            ack rdata rdy | req addr          vld inst pc
        add(0, 32'h0,          0, 0,   0,  0, 32'h8000_0000, 0, 0,  32'h0);          // c0  IDLE
        add(0, 32'h0,          1, A0,  0,  1, 32'h8000_0000, 0, 0,  32'h0);          // c1  REQ ack
        add(0, 32'h0,          0, 0,   1,  0, 32'h8000_0000, 1, A0, 32'h8000_0000);  // c2  HOLD take
        add(0, 32'h0,          1, A1,  0,  1, 32'h8000_0004, 0, A0, 32'h8000_0000);  // c3
        for (int i = 0; i < 5; i++)
            add(0, 32'h0,      0, 0,   0,  0, 32'h8000_0004, 1, A1, 32'h8000_0004);  // c4-8 stall
        add(0, 32'h0,          0, 0,   1,  0, 32'h8000_0004, 1, A1, 32'h8000_0004);  // c9  take
        add(0, 32'h0,          1, A2,  0,  1, 32'h8000_0008, 0, A1, 32'h8000_0004);  // c10
        add(0, 32'h0,          0, 0,   1,  0, 32'h8000_0008, 1, A2, 32'h8000_0008);  // c11
        add(0, 32'h0,          1, A3,  0,  1, 32'h8000_000C, 0, A2, 32'h8000_0008);  // c12
        add(0, 32'h0,          0, 0,   1,  0, 32'h8000_000C, 1, A3, 32'h8000_000C);  // c13
        add(0, 32'h0,          1, A4,  0,  1, 32'h8000_0010, 0, A3, 32'h8000_000C);  // c14
        add(1, 32'h8000_0103,  0, 0,   0,  0, 32'h8000_0010, 1, A4, 32'h8000_0010);  // c15 redirect in HOLD
        add(0, 32'h0,          1, A5,  0,  1, 32'h8000_0100, 0, A4, 32'h8000_0010);  // c16
        add(1, 32'h8000_0020,  0, 0,   1,  0, 32'h8000_0100, 1, A5, 32'h8000_0100);  // c17 redirect+ready
        add(1, 32'h8000_0200,  0, 0,   0,  1, 32'h8000_0020, 0, A5, 32'h8000_0100);  // c18 redirect in REQ
        add(0, 32'h0,          0, 0,   0,  1, 32'h8000_0020, 0, A5, 32'h8000_0100);  // c19 DISCARD wait
        add(1, 32'h8000_0300,  0, 0,   0,  1, 32'h8000_0020, 0, A5, 32'h8000_0100);  // c20 second redirect
        add(0, 32'h0,          1, BAD, 1,  1, 32'h8000_0020, 0, A5, 32'h8000_0100);  // c21 stale ack
        add(0, 32'h0,          1, A6,  0,  1, 32'h8000_0300, 0, A5, 32'h8000_0100);  // c22
        add(1, 32'hFFFF_FFFF,  0, 0,   0,  0, 32'h8000_0300, 1, A6, 32'h8000_0300);  // c23 redirect to top
        add(0, 32'h0,          1, A7,  0,  1, 32'hFFFF_FFFC, 0, A6, 32'h8000_0300);  // c24
        add(0, 32'h0,          0, 0,   1,  0, 32'hFFFF_FFFC, 1, A7, 32'hFFFF_FFFC);  // c25 take -> wrap
        add(1, 32'h8000_0400,  1, BAD, 0,  1, 32'h0000_0000, 0, A7, 32'hFFFF_FFFC);  // c26 ack+redirect
        add(1, 32'h8000_0500,  0, 0,   0,  1, 32'h8000_0400, 0, A7, 32'hFFFF_FFFC);  // c27 -> DISCARD
        add(1, 32'h8000_0600,  1, BAD, 0,  1, 32'h8000_0400, 0, A7, 32'hFFFF_FFFC);  // c28 ack+redirect in DISCARD
        add(0, 32'h0,          0, 0,   0,  1, 32'h8000_0600, 0, A7, 32'hFFFF_FFFC);  // c29 waiting

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            imem_ack_i    = vecs[i].ack;
            imem_rdata_i  = vecs[i].rdata;
            ready_i_ifu   = vecs[i].rdy;
            #1;
            chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_inst, vecs[i].e_pc);
            @(posedge clk);
            #1;
        end

        // Async reset while a request is outstanding
        redirect_i = 1'b0; imem_ack_i = 1'b0; ready_i_ifu = 1'b0; imem_rdata_i = 32'h0;
        #1;
        chk_all(100, 1'b1, 32'h8000_0600, 1'b0, A7, 32'hFFFF_FFFC);
        #1;
        rst = 1'b0;
        #1;
        chk_all(101, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all(102, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = A8;
        chk_all(103, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        imem_ack_i  = 1'b0;
        ready_i_ifu = 1'b1;
        chk_all(104, 1'b0, 32'h8000_0000, 1'b1, A8, 32'h8000_0000);
        @(posedge clk);
        #1;
        chk_all(105, 1'b1, 32'h8000_0004, 1'b0, A8, 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: producer of the instruction/PC stream consumed by the decoder. Holds the architectural fetch PC, issues word requests to instruction memory over a req/ack handshake, buffers each returned instruction with its PC, and presents it to the decoder under valid/ready. Accepts redirects (branch/jump targets) from execute and discards stale fetch results.

## Interface

- RESET_PC, 32'h8000_0000, fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, word aligned
- imem_ack_i  in  1  request accepted; imem_rdata_i valid this cycle
- imem_rdata_i  in  32  instruction word
- inst_o_ifu  out  32  instruction to decoder
- pc_o_ifu  out  32  PC of inst_o_ifu
- valid_o_ifu  out  1  inst_o_ifu/pc_o_ifu valid
- ready_i_ifu  in  1  decoder accepts this cycle
- redirect_i  in  1  replace fetch PC
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored, forced to 00

## Operation

- State machine, four states:
  - IDLE: reset state; req 0; next cycle -> REQ.
  - REQ: req 1, addr = fetch_pc. On ack: capture rdata and fetch_pc into output buffer -> HOLD.
  - HOLD: valid 1; req 0. On valid & ready: fetch_pc += 4 -> REQ.
  - DISCARD: req 1, addr = old fetch_pc (unchanged); waiting for ack of a request killed by redirect. On ack: drop rdata -> REQ with pending PC.
- Request rule: once req is asserted, addr stays stable and req stays high until ack. No withdrawal, even on redirect.
- Redirect handling (redirect_i = 1):
  - REQ, no ack: latch redirect_pc as pending -> DISCARD.
  - REQ, ack same cycle: drop rdata; fetch_pc <= redirect_pc -> REQ.
  - HOLD: drop buffered instruction; fetch_pc <= redirect_pc -> REQ. If ready was also 1, the handshake counts as completed for the decoder, but the next PC is redirect_pc, not pc+4.
  - DISCARD: pending PC overwritten (latest wins); ack same cycle uses the new value.
  - IDLE: fetch_pc <= redirect_pc -> REQ.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
- Output buffer is written only on ack in REQ. It holds its value in all other states.

## Timing

- Reset (rst = 0, async): state IDLE, fetch_pc = RESET_PC, pending = 0. Outputs: imem_req_o 0, imem_addr_o RESET_PC, valid_o_ifu 0, inst_o_ifu 0, pc_o_ifu 0.
- Reset mid-request: the request is abandoned immediately. After release, the first edge enters REQ at RESET_PC; req is first high one cycle after release.
- Ack in cycle N (state REQ) -> valid_o_ifu high from cycle N+1.
- Handshake in cycle M -> next req high in cycle M+1, at the PC of the accepted instruction + 4.
- Best-case throughput: one instruction per 2 cycles (ack-cycle, hold-cycle). This applies with a zero-wait memory and ready tied high.
- Redirect in HOLD at cycle R -> valid_o_ifu low at R+1, req at redirect_pc at R+1.
- Redirect in REQ without ack -> every returned word is suppressed until the ack; the new request starts the cycle after that ack.
- valid_o_ifu, inst_o_ifu and pc_o_ifu are stable while valid is 1 and ready is 0.
- All outputs come from registers or decode of the state register only. There is no combinational path from imem_rdata_i or ready_i_ifu to any output.

## Test plan

- Reset release, memory acks every request immediately, ready = 1: req addrs 80000000, 80000004, 80000008. Each instruction valid the cycle after its ack, with matching pc_o_ifu.
- Backpressure: ready = 0 for 5 cycles while in HOLD at pc 80000004 -> valid stays 1, inst/pc unchanged, req stays 0. When ready rises, next req is at 80000008.
- Redirect to 80000103 in HOLD at pc 80000010 -> held instruction dropped, next req at 80000100, valid low for one cycle.
- Redirect to 80000200 while a REQ at 80000020 waits 3 cycles for ack -> addr stays 80000020 until the ack, that word is never valid, next req at 80000200. A second redirect to 80000300 during the wait -> next req at 80000300.
- Wrap: redirect to FFFFFFFC, then consume the instruction -> next req at 00000000.
- Async reset asserted mid-wait (req high, no ack) -> req and valid drop to 0 without a clock edge. After release, fetch restarts at 80000000.
